// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit active-low hex display driver with a double-buffered value.
// A new word is committed only at the end of a full scan frame.
module seg7_digit_enc #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       dp,
  input  logic       lz,     // this digit and every digit above it are zero
  output logic       blank,
  output logic [7:0] cat
);
  logic [6:0] hex;

  always_comb begin
    hex = 7'h7F;
    unique case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
    endcase
  end

  assign blank = !en || (BLANK_LZ && lz);
  assign cat   = {~dp, hex};
endmodule

module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_wr,
  input  logic        ctrl_wr,
  input  logic [31:0] wdata,
  output logic [31:0] disp_value,
  output logic        busy,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);
  localparam int NUM_DIGITS = 8;
  localparam int DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [31:0]      pending, committed;
  logic [7:0]       en_mask, dp_mask;

  logic wrap, boundary;
  assign wrap     = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign boundary = wrap && (idx == 3'd7);

  logic [NUM_DIGITS-1:0]      dig_blank;
  logic [NUM_DIGITS-1:0][7:0] dig_cat;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    logic lz;
    // Digit 0 always shows, so a zero value still displays "0".
    if (d == 0) begin : g_lsd
      assign lz = 1'b0;
    end else begin : g_upper
      assign lz = (committed[31:4*d] == '0);
    end
    seg7_digit_enc #(.BLANK_LZ(BLANK_LZ)) u_enc (
      .nib   (committed[4*d +: 4]),
      .en    (en_mask[d]),
      .dp    (dp_mask[d]),
      .lz    (lz),
      .blank (dig_blank[d]),
      .cat   (dig_cat[d])
    );
  end

  logic [7:0] an_nxt, cat_nxt;
  always_comb begin
    an_nxt  = 8'hFF;
    cat_nxt = 8'hFF;
    if (!dig_blank[idx]) begin
      an_nxt  = ~(8'h01 << idx);
      cat_nxt = dig_cat[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= '0;
      pending   <= '0;
      committed <= '0;
      busy      <= 1'b0;
      en_mask   <= 8'hFF;
      dp_mask   <= 8'h00;
      seg_an    <= 8'hFF;
      seg_cat   <= 8'hFF;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) idx <= idx + 3'd1;
      if (boundary && busy) committed <= pending;
      // A write on the boundary lands after the commit and waits a full frame.
      if (data_wr) begin
        pending <= wdata;
        busy    <= 1'b1;
      end else if (boundary) begin
        busy <= 1'b0;
      end
      if (ctrl_wr) begin
        en_mask <= wdata[7:0];
        dp_mask <= wdata[15:8];
      end
      seg_an  <= an_nxt;
      seg_cat <= cat_nxt;
    end
  end

  assign disp_value = committed;
endmodule
